// File: rtl/avl_resp_pkg.sv
// avl_resp_pkg
//   Shared defaults and types for the Avalon-MM RAM responder.
//   - RAM_ADDR_W_DEF / RAM_DATA_W_DEF : default bus widths
//   - READ_LATENCY_MIN/MAX            : legal read-latency range
//   - MAX_PENDING_MIN/SLACK           : legal outstanding-read range (1..latency+slack)
//   - rd_stage_t                      : one response-pipeline stage (valid, data)
package avl_resp_pkg;

  localparam int RAM_ADDR_W_DEF    = 26;
  localparam int RAM_DATA_W_DEF    = 128;

  localparam int READ_LATENCY_MIN  = 1;
  localparam int READ_LATENCY_MAX  = 8;

  localparam int MAX_PENDING_MIN   = 1;
  localparam int MAX_PENDING_SLACK = 4;

  typedef struct packed {
    logic                      valid;
    logic [RAM_DATA_W_DEF-1:0] data;
  } rd_stage_t;

  function automatic bit pending_legal(input int max_pending, input int read_latency);
    return (max_pending >= MAX_PENDING_MIN) &&
           (max_pending <= read_latency + MAX_PENDING_SLACK);
  endfunction

endpackage

// File: rtl/avl_resp_rdpipe.sv
// avl_resp_rdpipe
//   LATENCY-stage valid/data shift register carrying read responses.
//   The last stage only loads data when a valid response arrives, so the
//   output data holds the most recent response between pulses.
//   Ports:
//     iCLK      in   clock
//     clr       in   synchronous clear of all stages (valid and data)
//     in_stage  in   response entering the pipeline this cycle
//     out_stage out  response leaving the pipeline (registered)
module avl_resp_rdpipe
  import avl_resp_pkg::*;
#(
  parameter int  LATENCY = 2,
  parameter type stage_t = rd_stage_t
) (
  input  logic   iCLK,
  input  logic   clr,
  input  stage_t in_stage,
  output stage_t out_stage
);

  stage_t st  [LATENCY];
  stage_t src [LATENCY];

  always_comb begin
    src[0] = in_stage;
    for (int i = 1; i < LATENCY; i++) begin
      src[i] = st[i-1];
    end
  end

  always_ff @(posedge iCLK) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) begin
        st[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        st[i].valid <= src[i].valid;
        // final stage keeps its data when nothing valid arrives
        if (src[i].valid || (i < LATENCY - 1)) begin
          st[i].data <= src[i].data;
        end
      end
    end
  end

  assign out_stage = st[LATENCY-1];

endmodule

// File: rtl/avl_ram_responder.sv
// avl_ram_responder
//   Avalon-MM responder modelling a word-addressed RAM with fixed pipelined
//   read latency, bounded outstanding reads and wait-request back-pressure.
//   Optional feature macro: AVL_RESP_BYTEEN_EN (adds avl_byteenable; writes
//   update only enabled bytes).
//   Ports:
//     iCLK               in   clock, rising edge
//     iRST_n             in   synchronous active-low reset
//     avl_read           in   read request
//     avl_write          in   write request
//     avl_address        in   word address
//     avl_writedata      in   write data
//     avl_byteenable     in   byte enables (only with AVL_RESP_BYTEEN_EN)
//     avl_wait           out  wait-request, request not accepted while high
//     avl_readdatavalid  out  one-cycle pulse qualifying avl_readdata
//     avl_readdata       out  read data, holds last value between pulses
//     err_protocol       out  sticky: read and write in the same cycle
//     err_range          out  sticky: accepted access at address >= DEPTH
module avl_ram_responder
  import avl_resp_pkg::*;
#(
  parameter int RAM_ADDR_W   = RAM_ADDR_W_DEF,
  parameter int RAM_DATA_W   = RAM_DATA_W_DEF,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic                    avl_read,
  input  logic                    avl_write,
  input  logic [RAM_ADDR_W-1:0]   avl_address,
  input  logic [RAM_DATA_W-1:0]   avl_writedata,
`ifdef AVL_RESP_BYTEEN_EN
  input  logic [RAM_DATA_W/8-1:0] avl_byteenable,
`endif
  output logic                    avl_wait,
  output logic                    avl_readdatavalid,
  output logic [RAM_DATA_W-1:0]   avl_readdata,
  output logic                    err_protocol,
  output logic                    err_range
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0]   PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [RAM_ADDR_W:0] DEPTH_L  = (RAM_ADDR_W + 1)'(DEPTH);

  if ((READ_LATENCY < READ_LATENCY_MIN) || (READ_LATENCY > READ_LATENCY_MAX)) begin : g_bad_latency
    $error("avl_ram_responder: READ_LATENCY out of legal range");
  end
  if (!pending_legal(MAX_PENDING, READ_LATENCY)) begin : g_bad_pending
    $error("avl_ram_responder: MAX_PENDING out of legal range");
  end
  if ((DEPTH < 1) || (IDX_W > RAM_ADDR_W)) begin : g_bad_depth
    $error("avl_ram_responder: DEPTH does not fit the address width");
  end
  if ((RAM_DATA_W % 8) != 0) begin : g_bad_width
    $error("avl_ram_responder: RAM_DATA_W must be a whole number of bytes");
  end

  typedef struct packed {
    logic                  valid;
    logic [RAM_DATA_W-1:0] data;
  } stage_t;

  logic [RAM_DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic [PEND_W-1:0] pending;
  logic              collide;
  logic              rd_acc;
  logic              wr_acc;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  stage_t            rd_in;
  stage_t            rd_out;

  assign collide  = avl_read & avl_write;
  // a returning read frees its slot in the same cycle
  assign avl_wait = ~ready | ((pending == PEND_MAX) & ~avl_readdatavalid) | collide;
  assign rd_acc   = avl_read  & ~avl_wait;
  assign wr_acc   = avl_write & ~avl_wait;
  assign in_range = {1'b0, avl_address} < DEPTH_L;
  assign idx      = avl_address[IDX_W-1:0];

  assign rd_in.valid = rd_acc;
  assign rd_in.data  = in_range ? mem[idx] : '0;

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      ready        <= 1'b0;
      pending      <= '0;
      err_protocol <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      ready <= 1'b1;
      if (rd_acc && !avl_readdatavalid) begin
        pending <= pending + PEND_W'(1);
      end else if (!rd_acc && avl_readdatavalid) begin
        pending <= pending - PEND_W'(1);
      end
      if (collide) begin
        err_protocol <= 1'b1;
      end
      if ((rd_acc || wr_acc) && !in_range) begin
        err_range <= 1'b1;
      end
    end
  end

  // memory contents survive reset; writes are only blocked while it is held
  always_ff @(posedge iCLK) begin
    if (iRST_n && wr_acc && in_range) begin
`ifdef AVL_RESP_BYTEEN_EN
      for (int b = 0; b < RAM_DATA_W / 8; b++) begin
        if (avl_byteenable[b]) begin
          mem[idx][b*8 +: 8] <= avl_writedata[b*8 +: 8];
        end
      end
`else
      mem[idx] <= avl_writedata;
`endif
    end
  end

  avl_resp_rdpipe #(
    .LATENCY (READ_LATENCY),
    .stage_t (stage_t)
  ) u_rdpipe (
    .iCLK      (iCLK),
    .clr       (~iRST_n),
    .in_stage  (rd_in),
    .out_stage (rd_out)
  );

  assign avl_readdatavalid = rd_out.valid;
  assign avl_readdata      = rd_out.data;

endmodule

// File: tb/tb_avl_ram_responder.sv
module tb_avl_ram_responder;

  localparam int AW    = 26;
  localparam int DW    = 128;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4096;
  localparam int RL    = 3;
  localparam int MP    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be = '1;
  logic          avl_wait;
  logic          avl_readdatavalid;
  logic [DW-1:0] avl_readdata;
  logic          err_protocol;
  logic          err_range;

  avl_ram_responder #(
    .RAM_ADDR_W   (AW),
    .RAM_DATA_W   (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL),
    .MAX_PENDING  (MP)
  ) dut (
    .iCLK              (clk),
    .iRST_n            (rst_n),
    .avl_read          (rd),
    .avl_write         (wr),
    .avl_address       (addr),
    .avl_writedata     (wdata),
`ifdef AVL_RESP_BYTEEN_EN
    .avl_byteenable    (be),
`endif
    .avl_wait          (avl_wait),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata),
    .err_protocol      (err_protocol),
    .err_range         (err_range)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] last_rd_m = '0;
  bit            ready_m = 1'b0;
  bit            errp_m = 1'b0;
  bit            errr_m = 1'b0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] pool_addr(input int k);
    return (k < 16) ? AW'(k) : AW'(DEPTH - 6 + (k - 16));
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] d,
                                          input logic [BW-1:0] b);
`ifdef AVL_RESP_BYTEEN_EN
    logic [DW-1:0] r;
    r = old_w;
    for (int k = 0; k < BW; k++) begin
      if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    end
    return r;
`else
    return d;
`endif
  endfunction

  // Response monitor: every pulse must match the oldest outstanding read and
  // arrive exactly RL cycles after acceptance; between pulses data must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (avl_readdatavalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rdv", DW'(avl_readdatavalid), DW'(0));
        end else begin
          mon_e = q.pop_front();
          chk("rdv_cycle", DW'(cyc), DW'(mon_e.due));
          chk("rdata", avl_readdata, mon_e.data);
          last_rd_m = mon_e.data;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_rdv", DW'(avl_readdatavalid), DW'(1));
          void'(q.pop_front());
        end
        chk("rdata_hold", avl_readdata, last_rd_m);
      end
    end
  end

  // One bus cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] b);
    bit            returning;
    bit            exp_wait;
    bit            acc;
    bit            oor;
    logic [DW-1:0] old_w;
    rd = r; wr = w; addr = a; wdata = d; be = b;
    oor       = (a >= AW'(DEPTH));
    returning = (q.size() > 0) && (q[0].due == cyc);
    exp_wait  = !ready_m || ((q.size() >= MP) && !returning) || (r && w);
    acc       = (r ^ w) && !exp_wait;
    @(negedge clk);
    chk("avl_wait", DW'(avl_wait), DW'(exp_wait));
    chk("err_protocol", DW'(err_protocol), DW'(errp_m));
    chk("err_range", DW'(err_range), DW'(errr_m));
    if (acc && r) begin
      q.push_back('{data: (oor ? '0 : (mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0)),
                    due: cyc + RL});
    end
    @(posedge clk); #1;
    ready_m = 1'b1;
    if (r && w) errp_m = 1'b1;
    if (acc && oor) errr_m = 1'b1;
    if (acc && w && !oor) begin
      old_w = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
      mem_m[int'(a)] = merge(old_w, d, b);
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '1);
  endtask

  task automatic do_reset(input int n);
    rd = 1'b0; wr = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    last_rd_m = '0;
    ready_m = 1'b0; errp_m = 1'b0; errr_m = 1'b0;
    mon_en = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      chk("rst_wait", DW'(avl_wait), DW'(1));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, '0, '1);
  endtask

  initial begin
    int k;
    int op;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    do_reset(3);

    // write then read back next cycle
    step(1'b0, 1'b1, AW'(5), {4{32'h1111_1111}}, '1);
    step(1'b1, 1'b0, AW'(5), '0, '1);
    idle(RL + 1);

    // fill the address pool
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, pool_addr(i), rnd128(), '1);

    // back-to-back reads, throttled by MAX_PENDING
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, '1);
      while (rd == 1'b0 && q.size() > 0 && q[q.size()-1].due != cyc + RL - 1 && 0) ;
    end
    idle(RL + 2);

    // read+write collision: nothing accepted, memory unchanged
    step(1'b1, 1'b1, AW'(3), rnd128(), '1);
    step(1'b1, 1'b0, AW'(3), '0, '1);
    idle(RL + 1);

    // out-of-range accesses
    step(1'b1, 1'b0, AW'(DEPTH), '0, '1);
    step(1'b0, 1'b1, AW'(DEPTH), rnd128(), '1);
    step(1'b1, 1'b0, AW'(0), '0, '1);
    step(1'b1, 1'b0, AW'(DEPTH - 1), '0, '1);
    idle(RL + 2);

    // reset while reads are in flight
    step(1'b1, 1'b0, AW'(1), '0, '1);
    step(1'b1, 1'b0, AW'(2), '0, '1);
    do_reset(1);
    step(1'b1, 1'b0, AW'(5), '0, '1);
    step(1'b1, 1'b0, AW'(2), '0, '1);
    idle(RL + 2);

`ifdef AVL_RESP_BYTEEN_EN
    step(1'b0, 1'b1, AW'(9), '1, '1);
    step(1'b0, 1'b1, AW'(9), '0, BW'(16'h000F));
    step(1'b1, 1'b0, AW'(9), '0, '1);
    step(1'b0, 1'b1, AW'(9), '0, '0);
    step(1'b1, 1'b0, AW'(9), '0, '1);
    idle(RL + 2);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 19);
      k  = $urandom_range(0, 21);
      a  = pool_addr(k);
      if (op < 9) begin
        step(1'b1, 1'b0, a, '0, BW'({$urandom, $urandom}));
      end else if (op < 15) begin
        step(1'b0, 1'b1, a, rnd128(), BW'({$urandom, $urandom}));
      end else if (op < 17) begin
        step(1'b0, 1'b0, a, '0, '1);
      end else if (op == 17) begin
        step(1'b1, 1'b1, a, rnd128(), '1);
      end else begin
        a = ($urandom_range(0, 1) == 0) ? AW'(DEPTH + $urandom_range(0, 4)) : '1;
        step($urandom_range(0, 1) == 1, 1'b0, a, rnd128(), '1);
        step(1'b0, 1'b1, a, rnd128(), '1);
      end
    end
    idle(RL + 2);

    // final reset: flags clear, contents retained
    do_reset(2);
    step(1'b1, 1'b0, AW'(0), '0, '1);
    step(1'b1, 1'b0, AW'(DEPTH - 1), '0, '1);
    idle(RL + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
